// File: rtl/rs232_pkg.sv
// rtl/rs232_pkg.sv - shared constants, FSM state type and sample-point helpers for the RS-232 receiver
package rs232_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        BREAK
    } rx_state_t;

    function automatic int clog2(input longint unsigned value);
        int result;
        longint unsigned span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

    // Centre of bit k measured from the start edge, rounded down once per sample.
    function automatic longint unsigned sample_point(input longint unsigned clock_hz,
                                                     input longint unsigned baud,
                                                     input longint unsigned k);
        return (clock_hz * (2 * k + 1)) / (2 * baud);
    endfunction

endpackage

// File: rtl/rs232_sync2.sv
// rtl/rs232_sync2.sv - two-flop synchroniser for an idle-high asynchronous line
module rs232_sync2 (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rs232_rx_framed.sv
// rtl/rs232_rx_framed.sv - framed RS-232 receiver with holding register; parity checking enabled by RS232_RX_PARITY_EN
module rs232_rx_framed
    import rs232_pkg::*;
#(
    parameter int CLOCK_FREQ = 133000000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY     = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rs232_txd,
    output logic                 rs232_cts_n,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 framing_error,
    output logic                 parity_error,
    output logic                 overrun
);

`ifdef RS232_RX_PARITY_EN
    localparam int PAR_EN = (PARITY != PARITY_NONE) ? 1 : 0;
`else
    // No parity bit is ever expected in this build, whatever PARITY says.
    localparam int PAR_EN = 0 * PARITY;
`endif
    localparam int NUM_SAMPLES = 1 + DATA_BITS + PAR_EN + STOP_BITS;
    localparam longint unsigned LAST_PT =
        sample_point(64'(CLOCK_FREQ), 64'(BAUD_RATE), 64'(NUM_SAMPLES - 1));
    localparam int CW = (clog2(LAST_PT + 1) < 1) ? 1 : clog2(LAST_PT + 1);

    logic                 rxs;
    logic                 rx_prev;
    rx_state_t            state;
    logic [CW-1:0]        cnt;
    logic [3:0]           idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 ferr_acc;
    logic                 perr_acc;
    logic [CW-1:0]        pts [0:15];
    logic                 hit;
    logic                 last_stop;

    rs232_sync2 u_sync (
        .clock (clock),
        .reset (reset),
        .d     (rs232_txd),
        .q     (rxs)
    );

    for (genvar i = 0; i < 16; i++) begin : g_pts
        assign pts[i] = CW'(sample_point(64'(CLOCK_FREQ), 64'(BAUD_RATE), 64'(i)));
    end

    assign hit         = (cnt == pts[idx]);
    assign last_stop   = (state == STOP) && hit && (idx == 4'(NUM_SAMPLES - 1));
    assign rs232_cts_n = valid;

`ifdef RS232_RX_PARITY_EN
    logic par_exp;
    assign par_exp = (PARITY == PARITY_ODD) ? ~^shreg : ^shreg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perr_acc     <= 1'b0;
            parity_error <= 1'b0;
        end else begin
            if (state == IDLE)
                perr_acc <= 1'b0;
            else if (state == PAR && hit)
                perr_acc <= rxs ^ par_exp;
            if (last_stop && (!valid || ready))
                parity_error <= perr_acc;
        end
    end
`else
    assign perr_acc     = 1'b0;
    assign parity_error = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            shreg         <= '0;
            ferr_acc      <= 1'b0;
            rx_prev       <= 1'b1;
            data          <= '0;
            valid         <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            rx_prev <= rxs;
            overrun <= 1'b0;
            // One free-running count per frame keeps rounding error from accumulating.
            if (state inside {START, DATA, PAR, STOP}) begin
                cnt <= cnt + CW'(1);
                if (hit)
                    idx <= idx + 4'd1;
            end
            case (state)
                IDLE: if (rx_prev && !rxs) begin
                    state    <= START;
                    cnt      <= '0;
                    idx      <= '0;
                    ferr_acc <= 1'b0;
                end
                START: if (hit)
                    state <= rxs ? IDLE : DATA;
                DATA: if (hit) begin
                    shreg <= {rxs, shreg[DATA_BITS-1:1]};
                    if (idx == 4'(DATA_BITS)) begin
                        if (PAR_EN != 0)
                            state <= PAR;
                        else
                            state <= STOP;
                    end
                end
                PAR: if (hit)
                    state <= STOP;
                STOP: if (hit) begin
                    if (!rxs)
                        ferr_acc <= 1'b1;
                    if (idx == 4'(NUM_SAMPLES - 1))
                        state <= (ferr_acc || !rxs) ? BREAK : IDLE;
                end
                BREAK: if (rxs)
                    state <= IDLE;
                default: state <= IDLE;
            endcase

            // A full, unacknowledged holding register drops the new frame.
            if (last_stop) begin
                if (!valid || ready) begin
                    data          <= shreg;
                    framing_error <= ferr_acc | ~rxs;
                    valid         <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule
